// File: rtl/wgt_bank_ring.sv
// N-bank weight SRAM ring: DMA fills banks in order, the array drains them in the same order.
// Bank ownership (filling vs. full) is tracked internally by two pointers and a full-bank count.
module wgt_bank_ring #(
   parameter int TN         = 14,
   parameter int DATA_W     = 8,
   parameter int ADDR_WIDTH = 7,
   parameter int NBANKS     = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   input  logic [ADDR_WIDTH-1:0]       wr_addr,
   input  logic [TN*DATA_W-1:0]        wr_data,
   input  logic                        wr_last,
   input  logic                        rd_req,
   input  logic [ADDR_WIDTH-1:0]       rd_addr,
   input  logic                        rd_release,
   output logic                        rd_avail,
   output logic [TN*DATA_W-1:0]        b_vec,
   output logic                        b_valid,
   output logic [$clog2(NBANKS)-1:0]   wr_bank,
   output logic [$clog2(NBANKS)-1:0]   rd_bank,
   output logic [$clog2(NBANKS+1)-1:0] full_banks,
   output logic                        err
);

   localparam int BW    = $clog2(NBANKS);
   localparam int CW    = $clog2(NBANKS + 1);
   localparam int W     = TN * DATA_W;
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [W-1:0] mem [NBANKS][DEPTH];

   logic accept;
   logic commit;
   logic read_ok;
   logic rel_ok;

   function automatic logic [BW-1:0] next_ptr(input logic [BW-1:0] p);
      return (p == BW'(NBANKS - 1)) ? '0 : p + BW'(1);
   endfunction

   always_comb begin
      wr_ready = (full_banks != CW'(NBANKS));
      rd_avail = (full_banks != '0);
      accept   = wr_valid & wr_ready;
      commit   = accept & wr_last;
      read_ok  = rd_req & rd_avail;
      rel_ok   = rd_release & rd_avail;
   end

   // SRAM array: not reset, contents survive reset.
   always_ff @(posedge clk) begin
      if (accept) mem[wr_bank][wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_bank    <= '0;
         rd_bank    <= '0;
         full_banks <= '0;
         b_vec      <= '0;
         b_valid    <= 1'b0;
         err        <= 1'b0;
      end else begin
         if (commit) wr_bank <= next_ptr(wr_bank);
         if (rel_ok) rd_bank <= next_ptr(rd_bank);
         // Commit and release in the same cycle cancel; rd_avail/wr_ready gate the range.
         if (commit && !rel_ok)      full_banks <= full_banks + CW'(1);
         else if (!commit && rel_ok) full_banks <= full_banks - CW'(1);
         b_valid <= read_ok;
         if (read_ok) b_vec <= mem[rd_bank][rd_addr];
         err <= (rd_req | rd_release) & ~rd_avail;
      end
   end

endmodule

// File: tb/tb_wgt_bank_ring.sv
// Directed self-checking bench for wgt_bank_ring: a 2-bank instance and a 4-bank instance.
module tb_wgt_bank_ring;

   localparam int TN = 14;
   localparam int DW = 8;
   localparam int AW = 7;
   localparam int W  = TN * DW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // 2-bank instance
   logic          a_rst, a_wr_valid, a_wr_ready, a_wr_last, a_rd_req, a_rd_release, a_rd_avail;
   logic          a_b_valid, a_err;
   logic [AW-1:0] a_wr_addr, a_rd_addr;
   logic [W-1:0]  a_wr_data, a_b_vec;
   logic [0:0]    a_wr_bank, a_rd_bank;
   logic [1:0]    a_full;

   // 4-bank instance
   logic          b_rst, b_wr_valid, b_wr_ready, b_wr_last, b_rd_req, b_rd_release, b_rd_avail;
   logic          b_b_valid, b_err;
   logic [AW-1:0] b_wr_addr, b_rd_addr;
   logic [W-1:0]  b_wr_data, b_b_vec;
   logic [1:0]    b_wr_bank, b_rd_bank;
   logic [2:0]    b_full;

   wgt_bank_ring #(.TN(TN), .DATA_W(DW), .ADDR_WIDTH(AW), .NBANKS(2)) dut_a (
      .clk(clk), .rst(a_rst), .wr_valid(a_wr_valid), .wr_ready(a_wr_ready),
      .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_last(a_wr_last),
      .rd_req(a_rd_req), .rd_addr(a_rd_addr), .rd_release(a_rd_release),
      .rd_avail(a_rd_avail), .b_vec(a_b_vec), .b_valid(a_b_valid),
      .wr_bank(a_wr_bank), .rd_bank(a_rd_bank), .full_banks(a_full), .err(a_err)
   );

   wgt_bank_ring #(.TN(TN), .DATA_W(DW), .ADDR_WIDTH(AW), .NBANKS(4)) dut_b (
      .clk(clk), .rst(b_rst), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
      .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_last(b_wr_last),
      .rd_req(b_rd_req), .rd_addr(b_rd_addr), .rd_release(b_rd_release),
      .rd_avail(b_rd_avail), .b_vec(b_b_vec), .b_valid(b_b_valid),
      .wr_bank(b_wr_bank), .rd_bank(b_rd_bank), .full_banks(b_full), .err(b_err)
   );

   function automatic logic [W-1:0] rowv(input logic [7:0] b);
      return {TN{b}};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      a_rst = 1'b1; a_wr_valid = 1'b0; a_wr_last = 1'b0; a_rd_req = 1'b0; a_rd_release = 1'b0;
      a_wr_addr = '0; a_rd_addr = '0; a_wr_data = '0;
      b_rst = 1'b1; b_wr_valid = 1'b0; b_wr_last = 1'b0; b_rd_req = 1'b0; b_rd_release = 1'b0;
      b_wr_addr = '0; b_rd_addr = '0; b_wr_data = '0;
      @(negedge clk);
      a_rst = 1'b0; b_rst = 1'b0;

      // Reset state
      chk("rst_wr_bank", a_wr_bank, 0);
      chk("rst_rd_bank", a_rd_bank, 0);
      chk("rst_full", a_full, 0);
      chk("rst_b_vec", a_b_vec, 0);
      chk("rst_b_valid", a_b_valid, 0);
      chk("rst_err", a_err, 0);
      chk("rst_wr_ready", a_wr_ready, 1);
      chk("rst_rd_avail", a_rd_avail, 0);

      // Illegal read and release from reset
      a_rd_req = 1'b1; a_rd_release = 1'b1;
      tick();
      a_rd_req = 1'b0; a_rd_release = 1'b0;
      chk("ill_err", a_err, 1);
      chk("ill_b_valid", a_b_valid, 0);
      chk("ill_rd_bank", a_rd_bank, 0);
      chk("ill_full", a_full, 0);
      tick();
      chk("ill_err_pulse", a_err, 0);

      // Fill bank0 rows 0..127
      for (int i = 0; i < 128; i++) begin
         a_wr_valid = 1'b1; a_wr_addr = AW'(i); a_wr_data = rowv(8'(i)); a_wr_last = (i == 127);
         tick();
      end
      a_wr_valid = 1'b0; a_wr_last = 1'b0;
      chk("fill_full", a_full, 1);
      chk("fill_wr_bank", a_wr_bank, 1);
      chk("fill_rd_avail", a_rd_avail, 1);

      // Back-to-back reads
      a_rd_req = 1'b1; a_rd_addr = 7'd5;
      tick();
      chk("rd5_vec", a_b_vec, rowv(8'h05));
      chk("rd5_valid", a_b_valid, 1);
      a_rd_addr = 7'd127;
      tick();
      a_rd_req = 1'b0;
      chk("rd127_vec", a_b_vec, rowv(8'h7F));
      chk("rd127_valid", a_b_valid, 1);
      tick();
      chk("idle_valid", a_b_valid, 0);
      chk("idle_hold", a_b_vec, rowv(8'h7F));

      // Commit bank1 (rows 0..3), all banks full
      for (int i = 0; i < 4; i++) begin
         a_wr_valid = 1'b1; a_wr_addr = AW'(i); a_wr_data = rowv(8'(8'h40 + i)); a_wr_last = (i == 3);
         tick();
      end
      chk("full2_full", a_full, 2);
      chk("full2_wr_ready", a_wr_ready, 0);
      chk("full2_wr_bank", a_wr_bank, 0);
      a_wr_addr = 7'd5; a_wr_data = rowv(8'hEE); a_wr_last = 1'b1;
      tick();
      a_wr_valid = 1'b0; a_wr_last = 1'b0;
      chk("drop_full", a_full, 2);
      chk("drop_wr_bank", a_wr_bank, 0);
      chk("drop_err", a_err, 0);
      a_rd_req = 1'b1; a_rd_addr = 7'd5;
      tick();
      a_rd_req = 1'b0;
      chk("drop_rd_vec", a_b_vec, rowv(8'h05));

      // Release bank0, read bank1
      a_rd_release = 1'b1;
      tick();
      a_rd_release = 1'b0;
      chk("rel_full", a_full, 1);
      chk("rel_rd_bank", a_rd_bank, 1);
      a_rd_req = 1'b1; a_rd_addr = 7'd2;
      tick();
      a_rd_req = 1'b0;
      chk("rd_b1_vec", a_b_vec, rowv(8'h42));

      // Commit bank0 and release bank1 in the same cycle
      a_wr_valid = 1'b1; a_wr_addr = 7'd9; a_wr_data = rowv(8'h99); a_wr_last = 1'b1;
      a_rd_release = 1'b1;
      tick();
      a_wr_valid = 1'b0; a_wr_last = 1'b0; a_rd_release = 1'b0;
      chk("sim_full", a_full, 1);
      chk("sim_rd_bank", a_rd_bank, 0);
      chk("sim_wr_bank", a_wr_bank, 1);

      // Read with release in the same cycle uses the pre-advance bank
      a_rd_req = 1'b1; a_rd_addr = 7'd9; a_rd_release = 1'b1;
      tick();
      a_rd_req = 1'b0; a_rd_release = 1'b0;
      chk("rdrel_vec", a_b_vec, rowv(8'h99));
      chk("rdrel_valid", a_b_valid, 1);
      chk("rdrel_rd_bank", a_rd_bank, 1);
      chk("rdrel_full", a_full, 0);

      // Commit with full_banks==0 plus release: release is illegal
      a_wr_valid = 1'b1; a_wr_addr = 7'd0; a_wr_data = rowv(8'h33); a_wr_last = 1'b1;
      a_rd_release = 1'b1;
      tick();
      a_wr_valid = 1'b0; a_wr_last = 1'b0; a_rd_release = 1'b0;
      chk("cz_full", a_full, 1);
      chk("cz_err", a_err, 1);
      chk("cz_rd_bank", a_rd_bank, 1);
      chk("cz_wr_bank", a_wr_bank, 0);

      // 4-bank ring: commit 4 banks
      for (int k = 0; k < 4; k++) begin
         b_wr_valid = 1'b1; b_wr_addr = 7'd3; b_wr_data = rowv(8'(8'h10 + k)); b_wr_last = 1'b1;
         tick();
      end
      b_wr_valid = 1'b0; b_wr_last = 1'b0;
      chk("n4_full", b_full, 4);
      chk("n4_wr_ready", b_wr_ready, 0);
      chk("n4_wr_bank", b_wr_bank, 0);

      // Release 1 (reading it on the way out)
      b_rd_req = 1'b1; b_rd_addr = 7'd3; b_rd_release = 1'b1;
      tick();
      b_rd_req = 1'b0; b_rd_release = 1'b0;
      chk("n4_rel_vec", b_b_vec, rowv(8'h10));
      chk("n4_rel_rd_bank", b_rd_bank, 1);
      chk("n4_rel_full", b_full, 3);

      // Commit 1 into the freed bank0
      b_wr_valid = 1'b1; b_wr_addr = 7'd3; b_wr_data = rowv(8'h50); b_wr_last = 1'b1;
      tick();
      b_wr_valid = 1'b0; b_wr_last = 1'b0;
      chk("n4_c_full", b_full, 4);
      chk("n4_c_wr_bank", b_wr_bank, 1);

      // Drain 4: banks 1,2,3 then wrapped 0
      begin
         logic [7:0] exp_b [4];
         logic [1:0] exp_rb [4];
         exp_b[0] = 8'h11; exp_b[1] = 8'h12; exp_b[2] = 8'h13; exp_b[3] = 8'h50;
         exp_rb[0] = 2'd2; exp_rb[1] = 2'd3; exp_rb[2] = 2'd0; exp_rb[3] = 2'd1;
         for (int k = 0; k < 4; k++) begin
            b_rd_req = 1'b1; b_rd_addr = 7'd3; b_rd_release = 1'b1;
            tick();
            chk($sformatf("n4_drain%0d_vec", k), b_b_vec, rowv(exp_b[k]));
            chk($sformatf("n4_drain%0d_rd_bank", k), b_rd_bank, exp_rb[k]);
         end
      end
      b_rd_req = 1'b0; b_rd_release = 1'b0;
      chk("n4_drain_full", b_full, 0);
      chk("n4_drain_avail", b_rd_avail, 0);

      // Partial fill then asynchronous reset mid-cycle
      b_wr_valid = 1'b1; b_wr_addr = 7'd0; b_wr_data = rowv(8'h77); b_wr_last = 1'b0;
      tick();
      b_wr_valid = 1'b0;
      b_rd_req = 1'b1;
      tick();
      b_rd_req = 1'b0;
      chk("n4_pre_err", b_err, 1);
      #2 b_rst = 1'b1;
      #1;
      chk("n4_arst_wr_bank", b_wr_bank, 0);
      chk("n4_arst_rd_bank", b_rd_bank, 0);
      chk("n4_arst_full", b_full, 0);
      chk("n4_arst_b_vec", b_b_vec, 0);
      chk("n4_arst_b_valid", b_b_valid, 0);
      chk("n4_arst_err", b_err, 0);
      @(negedge clk);
      b_rst = 1'b0;
      tick();
      chk("n4_post_full", b_full, 0);
      chk("n4_post_wr_bank", b_wr_bank, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
